// File: rtl/fcmp_result_queue.sv
// Result queue for the FP compare unit: NaN correction, fflags generation and a
// small FIFO toward the CDB. Define FCMP_BYPASS_EN for a same-cycle empty-queue bypass.
module fcmp_result_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAG_W-1:0]         in_tag,
  input  logic [1:0]               in_mode,
  input  logic                     in_result,
  input  logic [31:0]              in_a_operand,
  input  logic [31:0]              in_b_operand,
  output logic                     cdb_valid,
  input  logic                     cdb_ready,
  output logic [TAG_W-1:0]         cdb_tag,
  output logic [31:0]              cdb_data,
  output logic [4:0]               cdb_fflags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             res;
    logic             nv;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          inEntry;
  entry_t          headEntry;
  logic [PW-1:0]   rdPtr;
  logic [PW-1:0]   wrPtr;

  logic aNan, bNan, aSnan, bSnan, anyNan;
  logic corrRes, corrNv;
  logic pushFire, popFire, doWrite, doRead, bypassAct, queueNonEmpty;

  // The sign bits never influence classification.
  logic unusedSign;
  assign unusedSign = in_a_operand[31] ^ in_b_operand[31];

  always_comb begin
    aNan    = (in_a_operand[30:23] == 8'hFF) && (in_a_operand[22:0] != 23'd0);
    bNan    = (in_b_operand[30:23] == 8'hFF) && (in_b_operand[22:0] != 23'd0);
    aSnan   = aNan && !in_a_operand[22];
    bSnan   = bNan && !in_b_operand[22];
    anyNan  = aNan || bNan;
    corrRes = 1'b0;
    corrNv  = 1'b0;
    case (in_mode)
      2'b00: begin
        corrRes = anyNan ? 1'b0 : in_result;
        corrNv  = aSnan || bSnan;
      end
      2'b01, 2'b10: begin
        corrRes = anyNan ? 1'b0 : in_result;
        corrNv  = anyNan;
      end
      default: begin
        corrRes = 1'b0;
        corrNv  = 1'b0;
      end
    endcase
  end

  assign inEntry       = '{tag: in_tag, res: corrRes, nv: corrNv};
  assign headEntry     = mem[rdPtr];
  assign queueNonEmpty = (count != '0);
  assign in_ready      = (count < CW'(DEPTH));

`ifdef FCMP_BYPASS_EN
  assign bypassAct = !queueNonEmpty && in_valid && !flush;
`else
  assign bypassAct = 1'b0;
`endif

  assign cdb_valid = queueNonEmpty || bypassAct;
  assign pushFire  = in_valid && in_ready && !flush;
  assign popFire   = cdb_valid && cdb_ready && !flush;
  // A bypassed beat that is granted immediately never touches storage.
  assign doRead    = popFire && queueNonEmpty;
  assign doWrite   = pushFire && !(bypassAct && cdb_ready);

  always_comb begin
    cdb_tag    = '0;
    cdb_data   = '0;
    cdb_fflags = '0;
    if (queueNonEmpty) begin
      cdb_tag    = headEntry.tag;
      cdb_data   = {31'd0, headEntry.res};
      cdb_fflags = {headEntry.nv, 4'b0000};
    end else if (bypassAct) begin
      cdb_tag    = inEntry.tag;
      cdb_data   = {31'd0, inEntry.res};
      cdb_fflags = {inEntry.nv, 4'b0000};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (flush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= inEntry;
  end

endmodule

// File: tb/tb_fcmp_result_queue.sv
// Directed plus randomized bench for fcmp_result_queue against a queue-based reference model.
module tb_fcmp_result_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 6;
`ifdef FCMP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [1:0]        in_mode;
  logic              in_result;
  logic [31:0]       in_a_operand;
  logic [31:0]       in_b_operand;
  logic              cdb_valid;
  logic              cdb_ready;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_data;
  logic [4:0]        cdb_fflags;
  logic [2:0]        count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic [4:0]       fl;
  } ent_t;

  ent_t q[$];

  fcmp_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_mode(in_mode),
    .in_result(in_result), .in_a_operand(in_a_operand), .in_b_operand(in_b_operand),
    .cdb_valid(cdb_valid), .cdb_ready(cdb_ready), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_fflags(cdb_fflags), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected entry from the IEEE rules, using plain field arithmetic.
  function automatic ent_t mk(input logic [TAG_W-1:0] t, input logic [1:0] m, input bit r,
                              input logic [31:0] a, input logic [31:0] b);
    ent_t e;
    int unsigned ea, eb, fa, fb;
    bit na, nb, sa, sb, res, nv;
    ea = (a >> 23) & 32'hFF;  fa = a % 32'h0080_0000;
    eb = (b >> 23) & 32'hFF;  fb = b % 32'h0080_0000;
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    sa = na && (fa < 32'h0040_0000);
    sb = nb && (fb < 32'h0040_0000);
    res = (na || nb) ? 1'b0 : r;
    if (m == 2'b00)      nv = sa || sb;
    else if (m == 2'b11) begin nv = 1'b0; res = 1'b0; end
    else                 nv = na || nb;
    e.tag  = t;
    e.data = res ? 32'd1 : 32'd0;
    e.fl   = nv ? 5'd16 : 5'd0;
    return e;
  endfunction

  task automatic cycle(input bit v, input logic [TAG_W-1:0] t, input logic [1:0] m, input bit r,
                       input logic [31:0] a, input logic [31:0] b, input bit rdy, input bit fl);
    ent_t h;
    bit expV, expR, push, pop;
    in_valid = v; in_tag = t; in_mode = m; in_result = r;
    in_a_operand = a; in_b_operand = b; cdb_ready = rdy; flush = fl;
    #1;
    expR = (q.size() < DEPTH);
    if (q.size() != 0) begin
      expV = 1'b1; h = q[0];
    end else if (BYP && v && !fl) begin
      expV = 1'b1; h = mk(t, m, r, a, b);
    end else begin
      expV = 1'b0; h.tag = '0; h.data = '0; h.fl = '0;
    end
    chk("in_ready", 64'(in_ready), 64'(expR));
    chk("cdb_valid", 64'(cdb_valid), 64'(expV));
    chk("count", 64'(count), 64'(q.size()));
    chk("cdb_tag", 64'(cdb_tag), 64'(h.tag));
    chk("cdb_data", 64'(cdb_data), 64'(h.data));
    chk("cdb_fflags", 64'(cdb_fflags), 64'(h.fl));
    @(posedge clk);
    if (fl) q.delete();
    else begin
      push = v && expR;
      pop  = expV && rdy;
      if (!(BYP && q.size() == 0 && push && pop)) begin
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(mk(t, m, r, a, b));
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 5))
      0: x = {x[31], 8'($urandom_range(0, 254)), x[22:0]};
      1: x = {x[31], 8'hFF, 1'b1, x[21:0]};
      2: x = {x[31], 8'hFF, 1'b0, x[21:1], 1'b1};
      3: x = {x[31], 8'hFF, 23'd0};
      4: x = {x[31], 31'd0};
      default: ;
    endcase
    return x;
  endfunction

  task automatic idleCheck();
    in_valid = 1'b0; cdb_ready = 1'b0; flush = 1'b0;
    #1;
  endtask

  localparam logic [31:0] ONE  = 32'h3F80_0000;
  localparam logic [31:0] TWO  = 32'h4000_0000;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SNAN = 32'h7F80_0001;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_tag = '0; in_mode = '0;
    in_result = 1'b0; in_a_operand = '0; in_b_operand = '0; cdb_ready = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("rst_cdb_data", 64'(cdb_data), 64'd0);
    chk("rst_cdb_fflags", 64'(cdb_fflags), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // flt 1.0 < 2.0
    cycle(1, 6'd5, 2'b01, 1, ONE, TWO, 0, 0);
    idleCheck();
    chk("flt_valid", 64'(cdb_valid), 64'd1);
    chk("flt_tag", 64'(cdb_tag), 64'd5);
    chk("flt_data", 64'(cdb_data), 64'd1);
    chk("flt_fflags", 64'(cdb_fflags), 64'd0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // quiet NaN: feq is silent, fle raises NV
    cycle(1, 6'd6, 2'b00, 0, QNAN, ONE, 0, 0);
    idleCheck();
    chk("feq_qnan_data", 64'(cdb_data), 64'd0);
    chk("feq_qnan_fflags", 64'(cdb_fflags), 64'h00);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1, 6'd7, 2'b10, 0, QNAN, ONE, 0, 0);
    idleCheck();
    chk("fle_qnan_fflags", 64'(cdb_fflags), 64'h10);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // signalling NaN with a raw result of 1
    cycle(1, 6'd8, 2'b00, 1, SNAN, SNAN, 0, 0);
    idleCheck();
    chk("feq_snan_data", 64'(cdb_data), 64'd0);
    chk("feq_snan_fflags", 64'(cdb_fflags), 64'h10);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // fill to DEPTH, reject an extra push, then drain in order
    for (int i = 1; i <= 4; i++) cycle(1, 6'(i), 2'b01, 1, ONE, TWO, 0, 0);
    idleCheck();
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);
    cycle(1, 6'd7, 2'b01, 1, ONE, TWO, 0, 0);
    idleCheck();
    chk("full_count_after_extra", 64'(count), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      idleCheck();
      chk("pop_order", 64'(cdb_tag), 64'(i));
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
    end
    idleCheck();
    chk("drained_count", 64'(count), 64'd0);

    // steady push+pop at count 2, then flush
    cycle(1, 6'd10, 2'b01, 1, ONE, TWO, 0, 0);
    cycle(1, 6'd11, 2'b01, 1, ONE, TWO, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(1, 6'(12 + i), 2'b01, 1, ONE, TWO, 1, 0);
      idleCheck();
      chk("steady_count", 64'(count), 64'd2);
      chk("steady_head", 64'(cdb_tag), 64'(11 + i));
    end
    cycle(1, 6'd40, 2'b01, 1, ONE, TWO, 1, 1);
    idleCheck();
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(cdb_valid), 64'd0);

    // empty queue, input and grant in the same cycle
    in_valid = 1'b1; in_tag = 6'd9; in_mode = 2'b01; in_result = 1'b1;
    in_a_operand = ONE; in_b_operand = TWO; cdb_ready = 1'b1; flush = 1'b0;
    #1;
    chk("same_cycle_valid", 64'(cdb_valid), BYP ? 64'd1 : 64'd0);
    chk("same_cycle_tag", 64'(cdb_tag), BYP ? 64'd9 : 64'd0);
    cycle(1, 6'd9, 2'b01, 1, ONE, TWO, 1, 0);
    idleCheck();
    chk("same_cycle_count", 64'(count), BYP ? 64'd0 : 64'd1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    // randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 60), 6'($urandom), 2'($urandom), 1'($urandom),
            pickOperand(), pickOperand(), 1'($urandom_range(0, 99) < 50),
            1'($urandom_range(0, 99) < 3));
    end

    // asynchronous reset with entries in flight
    for (int i = 0; i < 3; i++) cycle(1, 6'(50 + i), 2'b10, 1, ONE, ONE, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(cdb_valid), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_data", 64'(cdb_data), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1, 6'd60, 2'b10, 1, ONE, ONE, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
